// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module  : fifo_sync_param
// Brief   : Single-clock FIFO, registered or first-word-fall-through read,
//           programmable almost flags and sticky overflow/underflow.
// Rev     : 1.0  initial release
// ============================================================================
module fifo_sync_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FWFT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic [ADDR_W:0]   ae_thresh,
  input  logic              err_clr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_wr_acc;
  logic              w_rd_acc;

  assign full         = (r_count == c_depth);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= af_thresh);
  assign almost_empty = (r_count <= ae_thresh);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  assign w_wr_acc = wr_en && !full;
  assign w_rd_acc = rd_en && !empty;

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error event takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && full)  r_overflow <= 1'b1;
      else if (err_clr)   r_overflow <= 1'b0;
      if (rd_en && empty) r_underflow <= 1'b1;
      else if (err_clr)   r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = empty ? '0 : r_mem[r_rptr];
      assign rd_valid = !empty;
    end else begin : g_reg
      logic [DATA_W-1:0] r_rd_data;
      logic              r_rd_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) r_rd_data <= r_mem[r_rptr];
        end
      end

      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// Bench for fifo_sync_param: registered-read and FWFT instances share stimulus
// and are checked every cycle against a queue model.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [4:0] af_thresh = 5'd12;
  logic [4:0] ae_thresh = 5'd3;

  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1;
  logic [4:0] count0, count1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(8), .ADDR_W(4), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .err_clr(err_clr), .count(count0), .full(full0),
    .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .overflow(ovf0), .underflow(unf0)
  );

  fifo_sync_param #(.DATA_W(8), .ADDR_W(4), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .err_clr(err_clr), .count(count1), .full(full1),
    .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of stored words plus sticky flags.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_rv = 1'b0;
  logic [7:0] m_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
      m_rd  = '0;
    end else begin
      automatic bit was_full  = (q.size() == 16);
      automatic bit was_empty = (q.size() == 0);
      if (wr_en && was_full) m_ovf = 1'b1;
      else if (err_clr)      m_ovf = 1'b0;
      if (rd_en && was_empty) m_unf = 1'b1;
      else if (err_clr)       m_unf = 1'b0;
      m_rv = rd_en && !was_empty;
      if (m_rv) m_rd = q.pop_front();
      if (wr_en && !was_full) q.push_back(wr_data);
    end
  end

  always @(posedge clk) begin
    #1;
    begin
      automatic int sz = q.size();
      automatic logic [7:0] head = (sz != 0) ? q[0] : 8'h00;
      check("count0", count0, sz);
      check("count1", count1, sz);
      check("full0", full0, sz == 16);
      check("full1", full1, sz == 16);
      check("empty0", empty0, sz == 0);
      check("empty1", empty1, sz == 0);
      check("almost_full0", af0, sz >= int'(af_thresh));
      check("almost_full1", af1, sz >= int'(af_thresh));
      check("almost_empty0", ae0, sz <= int'(ae_thresh));
      check("almost_empty1", ae1, sz <= int'(ae_thresh));
      check("overflow0", ovf0, m_ovf);
      check("overflow1", ovf1, m_ovf);
      check("underflow0", unf0, m_unf);
      check("underflow1", unf1, m_unf);
      check("rd_valid0", rd_valid0, m_rv);
      check("rd_data0", rd_data0, m_rd);
      check("rd_valid1", rd_valid1, sz != 0);
      check("rd_data1", rd_data1, head);
    end
  end

  // Inputs change 2 time units after the rising edge and hold for one cycle.
  task automatic cyc(input logic we, input logic [7:0] wd, input logic re, input logic clr);
    wr_en = we; wr_data = wd; rd_en = re; err_clr = clr;
    @(posedge clk); #2;
  endtask

  initial begin
    @(posedge clk); #2;
    check("reset count", count0, 0);
    check("reset empty", empty0, 1);
    check("reset full", full0, 0);
    check("reset rd_valid", rd_valid0, 0);
    check("reset rd_data", rd_data0, 0);
    check("reset almost_empty", ae0, 1);
    check("reset almost_full", af0, 0);
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);

    // Fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
    check("fill count", count0, 16);
    check("fill full", full0, 1);
    check("fill almost_full", af0, 1);
    cyc(1, 8'hFF, 0, 0);
    check("overflow set", ovf0, 1);
    check("overflow count", count0, 16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      check("drain rd_valid", rd_valid0, 1);
      check("drain rd_data", rd_data0, i);
    end
    cyc(0, 0, 0, 0);
    check("idle rd_valid", rd_valid0, 0);
    check("idle rd_data hold", rd_data0, 8'h0F);
    check("drained empty", empty0, 1);
    cyc(0, 0, 0, 1);
    check("overflow cleared", ovf0, 0);

    // Underflow and clear priority.
    cyc(0, 0, 1, 0);
    check("underflow set", unf0, 1);
    check("underflow count", count0, 0);
    check("underflow rd_valid", rd_valid0, 0);
    cyc(0, 0, 0, 1);
    check("underflow cleared", unf0, 0);
    cyc(0, 0, 1, 1);
    check("underflow set beats clear", unf0, 1);
    cyc(0, 0, 0, 1);

    // Simultaneous read/write at count 8 across several pointer wraps.
    for (int i = 0; i < 8; i++) cyc(1, 8'h40 + 8'(i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'h80 + 8'(i), 1, 0);
      check("simul count", count0, 8);
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
    check("simul last word", rd_data0, 8'hA7);
    check("simul empty", empty0, 1);

    // Threshold flags.
    for (int i = 0; i < 3; i++) cyc(1, 8'(i), 0, 0);
    check("ae at 3", ae0, 1);
    cyc(1, 8'h03, 0, 0);
    check("ae at 4", ae0, 0);
    for (int i = 4; i < 11; i++) cyc(1, 8'(i), 0, 0);
    check("af at 11", af0, 0);
    af_thresh = 5'd10;
    cyc(0, 0, 0, 0);
    check("af reprogrammed", af0, 1);
    af_thresh = 5'd12;
    cyc(0, 0, 0, 0);
    check("af restored", af0, 0);
    cyc(1, 8'h0B, 0, 0);
    check("af at 12", af0, 1);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0);

    // FWFT first word.
    cyc(1, 8'hA5, 0, 0);
    check("fwft rd_valid", rd_valid1, 1);
    check("fwft rd_data", rd_data1, 8'hA5);
    cyc(0, 0, 1, 0);
    check("fwft popped empty", empty1, 1);
    check("fwft popped rd_valid", rd_valid1, 0);
    check("reg read of A5", rd_data0, 8'hA5);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 9; i++) cyc(1, 8'h20 + 8'(i), 0, 0);
    check("pre-reset count", count0, 9);
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("async reset count", count0, 0);
    check("async reset empty", empty0, 1);
    check("async reset rd_valid0", rd_valid0, 0);
    check("async reset rd_valid1", rd_valid1, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    cyc(1, 8'h3C, 0, 0);
    cyc(0, 0, 1, 0);
    check("post-reset word", rd_data0, 8'h3C);

    // Randomized traffic with phase-varying bias.
    for (int p = 0; p < 8; p++) begin
      automatic int wbias = (p % 2 == 0) ? 80 : 25;
      af_thresh = 5'($urandom_range(0, 16));
      ae_thresh = 5'($urandom_range(0, 16));
      for (int i = 0; i < 50; i++) begin
        cyc($urandom_range(0, 99) < wbias, 8'($urandom),
            $urandom_range(0, 99) < (105 - wbias), $urandom_range(0, 15) == 0);
      end
    end
    cyc(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
